// File: rtl/bus_arbiter_if.sv
// +------------------------------------------------------------------+
// | bus_arbiter_if : request/data/grant bundle for bus_arbiter       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface bus_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24
);
  logic [NSRC-1:0]       src_en;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [NSRC-1:0]       grant;
  logic                  contention;
  logic                  contention_err;
  logic [7:0]            contention_cnt;

  modport master (
    output src_en, src_data,
    input  bus_out, bus_valid, grant, contention, contention_err, contention_cnt
  );

  modport slave (
    input  src_en, src_data,
    output bus_out, bus_valid, grant, contention, contention_err, contention_cnt
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// +------------------------------------------------------------------+
// | bus_arbiter : fixed-priority / round-robin bus mux with keeper;  |
// | contention monitor compiled in by BUS_ARBITER_CONTENTION_EN.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bus_arbiter #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int MODE  = 0
) (
  input  logic          clock,
  input  logic          clear,
  bus_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NSRC);

  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic [NSRC-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [IDX_W-1:0] lo_idx, hi_idx, win_idx;
  logic             hi_found;
  logic             any_req;
  logic [NSRC-1:0]  win_onehot;
  logic [WIDTH-1:0] win_data;

  // Descending scan: the last hit is the lowest index overall (lo) and
  // the lowest index at or above the round-robin pointer (hi).
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (bus.src_en[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr_q) begin
          hi_idx   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_req    = |bus.src_en;
    win_idx    = (MODE == 1 && hi_found) ? hi_idx : lo_idx;
    win_onehot = any_req ? (NSRC'(1) << win_idx) : '0;
    win_data   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win_onehot[i]) begin
        win_data = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus_out_d   = any_req ? win_data : bus_out_q;
    bus_valid_d = any_req;
    grant_d     = win_onehot;
    rr_ptr_d    = rr_ptr_q;
    if (any_req) begin
      rr_ptr_d = (win_idx == IDX_W'(NSRC - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.bus_out   = bus_out_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.grant     = grant_q;

`ifdef BUS_ARBITER_CONTENTION_EN
  logic       contention_q, contention_d;
  logic       contention_err_q, contention_err_d;
  logic [7:0] contention_cnt_q, contention_cnt_d;
  logic       multi_req;

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  always_comb begin
    multi_req        = |(bus.src_en & (bus.src_en - NSRC'(1)));
    contention_d     = multi_req;
    contention_err_d = contention_err_q | multi_req;
    contention_cnt_d = contention_cnt_q;
    if (multi_req && contention_cnt_q != 8'hFF) begin
      contention_cnt_d = contention_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      contention_q     <= 1'b0;
      contention_err_q <= 1'b0;
      contention_cnt_q <= 8'd0;
    end else begin
      contention_q     <= contention_d;
      contention_err_q <= contention_err_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign bus.contention     = contention_q;
  assign bus.contention_err = contention_err_q;
  assign bus.contention_cnt = contention_cnt_q;
`else
  assign bus.contention     = 1'b0;
  assign bus.contention_err = 1'b0;
  assign bus.contention_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bus data width in bits.
REQ-002 SHALL have parameter NSRC, default 24, number of bus sources (legal range 2..64).
REQ-003 SHALL have parameter MODE, default 0: 0 selects fixed priority, 1 selects round-robin.
REQ-004 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-005 SHALL have port clear  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port src_en  input  NSRC  per-source drive request; bit i requests source i.
REQ-007 SHALL have port src_data  input  NSRC*WIDTH  source i data on bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port bus_out  output  WIDTH  registered bus value.
REQ-009 SHALL have port bus_valid  output  1  high when bus_out was loaded in the previous cycle.
REQ-010 SHALL have port grant  output  NSRC  registered one-hot grant; all zero when idle.
REQ-011 SHALL have port contention  output  1  one-cycle pulse: two or more src_en bits were high in the previous cycle.
REQ-012 SHALL have port contention_err  output  1  sticky contention flag.
REQ-013 SHALL have port contention_cnt  output  8  saturating count of contention cycles.

Function
REQ-014 SHALL register all outputs; the response to src_en and src_data sampled at edge k SHALL appear after edge k (latency 1).
REQ-015 SHALL pick winner w when src_en is non-zero, and on that edge SHALL load bus_out with source w data, set grant to one-hot w, and set bus_valid to 1.
REQ-016 SHALL, when src_en is zero, hold bus_out at its last value (bus keeper, never X), drive grant to 0 and bus_valid to 0.
REQ-017 SHALL, with MODE=0, make w the lowest index with src_en set.
REQ-018 SHALL, with MODE=1, make w the first set index searching upward from rr_ptr and wrapping from NSRC-1 to 0.
REQ-019 SHALL hold rr_ptr as internal state of width clog2(NSRC).
REQ-020 SHALL, on each grant, update rr_ptr to w+1; w=NSRC-1 SHALL wrap rr_ptr to 0.
REQ-021 SHALL leave rr_ptr unchanged on idle cycles.
REQ-022 SHALL, with MODE=1 and a single requester, grant that requester on every cycle with no gaps.
REQ-023 SHALL ignore src_data of non-winning sources completely.
REQ-024 SHALL not treat src_en bits outside [NSRC-1:0] as requests; no such bits exist.

Reset
REQ-025 SHALL, when clear=0 at a rising edge, set bus_out=0, bus_valid=0, grant=0, rr_ptr=0, contention=0, contention_err=0 and contention_cnt=0.
REQ-026 SHALL give reset priority over any simultaneous request; the cycle after clear returns high SHALL use fresh arbitration with rr_ptr=0.
REQ-027 SHALL let reset during a contention burst clear the count and the sticky flag; counting SHALL restart from 0.

Configuration
REQ-028 SHALL use macro BUS_ARBITER_CONTENTION_EN to compile contention detection in or out.
REQ-029 SHALL, with the macro defined, pulse contention for one cycle after any edge where popcount(src_en) >= 2.
REQ-030 SHALL, with the macro defined, set contention_err on that pulse and hold it until reset.
REQ-031 SHALL, with the macro defined, increment contention_cnt per contention cycle and saturate at 255.
REQ-032 SHALL arbitrate normally regardless of contention.
REQ-033 SHALL, without the macro, tie contention, contention_err and contention_cnt to constant 0 with no detection logic synthesised.
REQ-034 SHALL keep the port list identical with and without the macro.

Verification
REQ-035 SHALL cover: MODE=0, src_en bit 5 only with data 0x0000_00A5 -> one cycle later bus_out=0x0000_00A5, grant bit 5 set, bus_valid=1.
REQ-036 SHALL cover: MODE=0, src_en bits 3 and 7 for one cycle, then src_en=0 -> grant bit 3 set; next cycle bus_valid=0 and bus_out holds source 3 data.
REQ-037 SHALL cover: MODE=1, src_en bits 0, 1 and 2 held for 6 cycles -> grants in order 0,1,2,0,1,2.
REQ-038 SHALL cover: MODE=1, src_en bit NSRC-1 only -> rr_ptr wraps to 0; then bits 0 and NSRC-1 -> grant bit 0.
REQ-039 SHALL cover: macro defined, two sources requesting for 300 cycles -> contention high each cycle, contention_err=1, contention_cnt saturates at 255; then clear=0 for 1 cycle -> all three read 0.
REQ-040 SHALL cover: clear=0 asserted while bits 2 and 4 request -> next cycle all outputs 0; first post-reset grant is bit 2 in both modes.
